// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide units: operation encodings,
// divider control state encoding and XLEN-wide helper constants.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SPECIAL = 2'd1,
        S_WAIT    = 2'd2,
        S_FIX     = 2'd3
    } div_state_e;

    localparam logic [MD_XLEN-1:0] INT_MIN  = {1'b1, {(MD_XLEN-1){1'b0}}};
    localparam logic [MD_XLEN-1:0] ALL_ONES = {MD_XLEN{1'b1}};

    function automatic logic [MD_XLEN-1:0] twos_neg(input logic [MD_XLEN-1:0] x);
        return ~x + {{(MD_XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_sign_ctrl.sv
// Signed/unsigned control wrapper around the unsigned iterative divider core:
// resolves divide-by-zero and overflow locally, otherwise sign-corrects the core result.
module div_sign_ctrl
    import muldiv_pkg::*;
#(
    // Package constants are sized by MD_XLEN, so XLEN must match it.
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [XLEN-1:0] div_a_o,
    output logic [XLEN-1:0] div_b_o,
    output logic            div_req_o,
    output logic            div_is_q_o,
    output logic            div_flush_o,
    input  logic [XLEN-1:0] div_result_i,
    input  logic            div_ready_i
);

    div_state_e      state_reg, state_next;
    logic [1:0]      op_reg, op_next;
    logic            sign_a_reg, sign_a_next;
    logic            sign_b_reg, sign_b_next;
    logic [XLEN-1:0] a_reg, a_next;
    logic [XLEN-1:0] b_reg, b_next;
    logic [XLEN-1:0] raw_reg, raw_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            done_reg, done_next;

    logic            in_signed;
    logic            rs2_zero;
    logic            overflow;
    logic            neg_en;

    assign in_signed = ~op_i[0];
    assign rs2_zero  = (rs2_i == '0);
    assign overflow  = in_signed && (rs1_i == INT_MIN) && (rs2_i == ALL_ONES);

    // Quotient is negative when signs differ; remainder follows the dividend.
    assign neg_en = op_reg[1] ? sign_a_reg : (sign_a_reg ^ sign_b_reg);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= S_IDLE;
            op_reg     <= 2'b00;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            raw_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            raw_reg    <= raw_next;
            result_reg <= result_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        raw_next    = raw_reg;
        result_next = result_reg;
        done_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (req_i && !done_reg && !flush_i) begin
                    op_next     = op_i;
                    sign_a_next = rs1_i[XLEN-1] & in_signed;
                    sign_b_next = rs2_i[XLEN-1] & in_signed;
                    a_next      = (rs1_i[XLEN-1] & in_signed) ? twos_neg(rs1_i) : rs1_i;
                    b_next      = (rs2_i[XLEN-1] & in_signed) ? twos_neg(rs2_i) : rs2_i;
                    // Special results are parked in raw_reg until S_SPECIAL publishes them.
                    if (rs2_zero) begin
                        raw_next   = op_i[1] ? rs1_i : ALL_ONES;
                        state_next = S_SPECIAL;
                    end else if (overflow) begin
                        raw_next   = op_i[1] ? '0 : INT_MIN;
                        state_next = S_SPECIAL;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_SPECIAL: begin
                result_next = raw_reg;
                done_next   = 1'b1;
                state_next  = S_IDLE;
            end
            S_WAIT: begin
                if (div_ready_i) begin
                    raw_next   = div_result_i;
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                result_next = neg_en ? twos_neg(raw_reg) : raw_reg;
                done_next   = 1'b1;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (flush_i) begin
            state_next  = S_IDLE;
            done_next   = 1'b0;
            result_next = '0;
        end
    end

    assign stall_o     = req_i & ~done_reg;
    assign done_o      = done_reg;
    assign result_o    = result_reg;
    assign div_a_o     = a_reg;
    assign div_b_o     = b_reg;
    assign div_req_o   = (state_reg == S_WAIT);
    assign div_is_q_o  = ~op_reg[1];
    assign div_flush_o = flush_i;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Randomized self-checking bench for div_sign_ctrl with a behavioural divider
// core and a signed-arithmetic reference model.
module tb_div_sign_ctrl;

    localparam logic [31:0] MINV = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        req;
    logic [1:0]  op_s;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic        div_req_o;
    logic        div_is_q_o;
    logic        div_flush_o;
    logic [31:0] div_result;
    logic        div_ready;

    int vectors    = 0;
    int miscompares = 0;
    int lat_force  = 0;

    logic        core_busy;
    int          core_cnt;

    div_sign_ctrl #(.XLEN(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .op_i         (op_s),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .flush_i      (flush),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .div_a_o      (div_a_o),
        .div_b_o      (div_b_o),
        .div_req_o    (div_req_o),
        .div_is_q_o   (div_is_q_o),
        .div_flush_o  (div_flush_o),
        .div_result_i (div_result),
        .div_ready_i  (div_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural unsigned divider core: random latency, one-cycle ready pulse.
    always @(posedge clk) begin
        div_ready <= 1'b0;
        if (rst || !div_req_o) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
        end else if (!core_busy) begin
            core_busy <= 1'b1;
            core_cnt  <= (lat_force != 0) ? lat_force : int'($urandom_range(1, 8));
        end else if (core_cnt <= 1) begin
            div_ready  <= 1'b1;
            div_result <= div_is_q_o ? (div_a_o / div_b_o) : (div_a_o % div_b_o);
            core_busy  <= 1'b0;
        end else begin
            core_cnt <= core_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics expressed with plain integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                if (b == 0) return ONES;
                if (a == MINV && b == ONES) return MINV;
                return 32'(sa / sb);
            end
            2'b01: return (b == 0) ? ONES : a / b;
            2'b10: begin
                if (b == 0) return a;
                if (a == MINV && b == ONES) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_r;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        bit          sgn;
        bit          special;
        bit          saw_req;
        bit          got_done;
        bit          ops_checked;
        int          n;
        int          rdy_at;
        exp_r   = ref_result(op, a, b);
        sgn     = ~op[0];
        exp_a   = (sgn && a[31]) ? -a : a;
        exp_b   = (sgn && b[31]) ? -b : b;
        special = (b == 0) || (sgn && a == MINV && b == ONES);
        saw_req = 0; got_done = 0; ops_checked = 0; n = 0; rdy_at = -1;

        @(negedge clk);
        req = 1'b1; op_s = op; rs1 = a; rs2 = b;
        #1;
        chk("stall", {31'b0, stall_o}, 32'd1);
        while (n < 100 && !got_done) begin
            @(posedge clk);
            #1;
            n++;
            if (div_req_o) begin
                saw_req = 1;
                if (!ops_checked) begin
                    chk("div_a", div_a_o, exp_a);
                    chk("div_b", div_b_o, exp_b);
                    chk("div_is_q", {31'b0, div_is_q_o}, {31'b0, ~op[1]});
                    ops_checked = 1;
                end
            end
            if (div_ready && rdy_at < 0) rdy_at = n;
            if (done_o) got_done = 1;
        end
        chk("done_seen", {31'b0, got_done}, 32'd1);
        chk("result", result_o, exp_r);
        if (special) begin
            chk("core_req_special", {31'b0, saw_req}, 32'd0);
            chk("special_latency", 32'(n), 32'd2);
        end else begin
            chk("core_req_normal", {31'b0, saw_req}, 32'd1);
            chk("fix_latency", 32'(n - rdy_at), 32'd2);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("done_pulse", {31'b0, done_o}, 32'd0);
        $display("op=%0d rs1=%h rs2=%h -> result=%h (ref %h) special=%0d", op, a, b,
                 result_o, exp_r, special);
    endtask

    // Abandon a long core operation with either flush or reset.
    task automatic run_abort(input bit use_rst);
        bit seen;
        bit seen_done;
        int n;
        seen = 0; seen_done = 0; n = 0;
        lat_force = 40;
        @(negedge clk);
        req = 1'b1; op_s = 2'b00; rs1 = 32'd1000; rs2 = 32'd3;
        while (n < 20 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (div_req_o) seen = 1;
        end
        chk("abort_req_seen", {31'b0, seen}, 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        req = 1'b0;
        #1;
        chk("div_flush", {31'b0, div_flush_o}, {31'b0, flush});
        @(posedge clk);
        #1;
        chk("abort_div_req", {31'b0, div_req_o}, 32'd0);
        chk("abort_result", result_o, 32'd0);
        chk("abort_done", {31'b0, done_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done_o || div_req_o) seen_done = 1;
        end
        chk("abort_quiet", {31'b0, seen_done}, 32'd0);
        lat_force = 0;
        $display("abort via %s: div_req=%0d result=%h", use_rst ? "reset" : "flush",
                 div_req_o, result_o);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return ONES;
            2: return MINV;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; req = 1'b0; op_s = 2'b00; rs1 = '0; rs2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_div_req", {31'b0, div_req_o}, 32'd0);
        chk("rst_div_a", div_a_o, 32'd0);
        chk("rst_div_b", div_b_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b00, MINV, ONES);
        run_op(2'b10, MINV, ONES);
        run_op(2'b01, 32'd5, 32'd0);
        run_op(2'b11, 32'd5, 32'd0);
        run_op(2'b00, 32'hFFFF_FFFB, 32'd0);
        run_op(2'b00, 32'd0, 32'd9);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            run_op(rop, pick(), pick());
        end

        run_abort(1'b0);
        run_op(2'b00, 32'd100, 32'd7);
        run_abort(1'b1);
        run_op(2'b00, 32'd100, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
